// File: rtl/calc_key_sequencer.sv
// ---------------------------------------------------------------------------
// calc_key_sequencer
//
// Purpose: sequences one two-operand calculator operation at a time.
// Keypad digits are accumulated into decimal operands A and B. The operator
// is latched, and a single start pulse is sent to the ALU. The sequencer then
// waits for done/err and shows either the operand being typed or the
// result/error.
//
// Optional feature: define ALU_TIMEOUT_EN to bound the ALU wait to TIMEOUT
// cycles. Without it, WAIT lasts until alu_done or reset.
//
// Ports:
//   clck        in   system clock, rising edge
//   reste       in   asynchronous active-low reset
//   key_valid   in   one-cycle key strobe
//   key_code    in   [3:0] 0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 DIV,
//                    14 EQUALS, 15 CLEAR
//   key_ready   out  keys accepted (low in START and WAIT)
//   alu_start   out  one-cycle start pulse to the ALU
//   alu_op      out  [1:0] 0 ADD, 1 SUB, 2 MUL, 3 DIV
//   alu_a       out  [WIDTH-1:0] operand A register
//   alu_b       out  [WIDTH-1:0] operand B register
//   alu_done    in   ALU result valid pulse
//   alu_result  in   [WIDTH-1:0] ALU result
//   alu_err     in   ALU error flag, valid with alu_done
//   disp_val    out  [WIDTH-1:0] value to display
//   disp_err    out  error indicator
//   state_o     out  [2:0] current state (debug)
// ---------------------------------------------------------------------------
module calc_key_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clck,
  input  logic             reste,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  output logic             alu_start,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_err,
  output logic [WIDTH-1:0] disp_val,
  output logic             disp_err,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    SHOW    = 3'd4,
    ERR     = 3'd5
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] disp_q;
  logic             err_q;

  // Appending a digit is evaluated in WIDTH+4 bits so that x*10+9 cannot
  // wrap. A digit that would overflow WIDTH is dropped and x is kept.
  function automatic logic [WIDTH-1:0] acc_digit(input logic [WIDTH-1:0] x,
                                                 input logic [3:0]       d);
    logic [WIDTH+3:0] t;
    t = {4'b0000, x} * (WIDTH+4)'(10) + {{WIDTH{1'b0}}, d};
    if (t <= {4'b0000, {WIDTH{1'b1}}}) acc_digit = t[WIDTH-1:0];
    else                                acc_digit = x;
  endfunction

  // Operator codes 10..13 map onto ALU opcodes 0..3.
  function automatic logic [1:0] key_to_op(input logic [3:0] k);
    key_to_op = 2'(k - 4'd10);
  endfunction

  logic             take;
  logic             is_digit;
  logic             is_oper;
  logic             is_equals;
  logic             is_clear;
  logic [WIDTH-1:0] acc_a_d;
  logic [WIDTH-1:0] acc_b_d;
  logic [WIDTH-1:0] digit_d;

  assign key_ready = (state_q != START) && (state_q != WAIT);
  assign alu_start = (state_q == START);
  assign take      = key_valid && key_ready;
  assign is_digit  = (key_code <= 4'd9);
  assign is_oper   = (key_code >= 4'd10) && (key_code <= 4'd13);
  assign is_equals = (key_code == 4'd14);
  assign is_clear  = (key_code == 4'd15);
  assign acc_a_d   = acc_digit(a_q, key_code);
  assign acc_b_d   = acc_digit(b_q, key_code);
  assign digit_d   = WIDTH'(key_code);

`ifdef ALU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT == 0);
`endif

  always_ff @(posedge clck or negedge reste) begin
    if (!reste) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      disp_q  <= '0;
      err_q   <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        ENTER_A: begin
          if (take) begin
            if (is_digit) begin
              a_q    <= acc_a_d;
              disp_q <= acc_a_d;
            end else if (is_oper) begin
              op_q    <= key_to_op(key_code);
              b_q     <= '0;
              state_q <= ENTER_B;
            end else if (is_clear) begin
              a_q    <= '0;
              disp_q <= '0;
            end
          end
        end

        ENTER_B: begin
          if (take) begin
            if (is_digit) begin
              b_q    <= acc_b_d;
              disp_q <= acc_b_d;
            end else if (is_oper) begin
              op_q <= key_to_op(key_code);
            end else if (is_equals) begin
              state_q <= START;
            end else if (is_clear) begin
              state_q <= ENTER_A;
              a_q     <= '0;
              b_q     <= '0;
              op_q    <= '0;
              disp_q  <= '0;
              err_q   <= 1'b0;
            end
          end
        end

        START: begin
          state_q <= WAIT;
`ifdef ALU_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end

        WAIT: begin
          if (alu_done) begin
            if (alu_err) begin
              err_q   <= 1'b1;
              state_q <= ERR;
            end else begin
              disp_q  <= alu_result;
              state_q <= SHOW;
            end
          end
`ifdef ALU_TIMEOUT_EN
          // Count reaching TIMEOUT on this edge means TIMEOUT full WAIT
          // cycles without a response; a same-cycle alu_done wins above.
          else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= ERR;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end

        SHOW: begin
          if (take) begin
            if (is_digit) begin
              a_q     <= digit_d;
              b_q     <= '0;
              disp_q  <= digit_d;
              state_q <= ENTER_A;
            end else if (is_oper) begin
              // Chain: the shown result becomes the next operand A.
              a_q     <= disp_q;
              op_q    <= key_to_op(key_code);
              b_q     <= '0;
              state_q <= ENTER_B;
            end else if (is_clear) begin
              state_q <= ENTER_A;
              a_q     <= '0;
              b_q     <= '0;
              op_q    <= '0;
              disp_q  <= '0;
              err_q   <= 1'b0;
            end
          end
        end

        ERR: begin
          if (take && is_clear) begin
            state_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            disp_q  <= '0;
            err_q   <= 1'b0;
          end
        end

        default: state_q <= ENTER_A;
      endcase
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign disp_val = disp_q;
  assign disp_err = err_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
module tb_calc_key_sequencer;

  localparam int WIDTH = 8;
  localparam int TMO   = 16;
  localparam int MAXV  = (1 << WIDTH) - 1;

  // Spec state encodings
  localparam int PH_A  = 0;
  localparam int PH_B  = 1;
  localparam int PH_S  = 2;
  localparam int PH_W  = 3;
  localparam int PH_SH = 4;
  localparam int PH_E  = 5;

  localparam int K_ADD = 10, K_SUB = 11, K_MUL = 12, K_DIV = 13, K_EQ = 14, K_CLR = 15;

  logic             clck = 1'b0;
  logic             reste = 1'b0;
  logic             key_valid = 1'b0;
  logic [3:0]       key_code = '0;
  logic             key_ready;
  logic             alu_start;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_done = 1'b0;
  logic [WIDTH-1:0] alu_result = '0;
  logic             alu_err = 1'b0;
  logic [WIDTH-1:0] disp_val;
  logic             disp_err;
  logic [2:0]       state_o;

  calc_key_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TMO)) dut (
    .clck(clck), .reste(reste), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .alu_start(alu_start), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done),
    .alu_result(alu_result), .alu_err(alu_err), .disp_val(disp_val),
    .disp_err(disp_err), .state_o(state_o)
  );

  initial forever #5 clck = ~clck;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ph = PH_A, m_a = 0, m_b = 0, m_op = 0, m_disp = 0, m_err = 0, m_wait = 0;

  function automatic void m_reset();
    m_ph = PH_A; m_a = 0; m_b = 0; m_op = 0; m_disp = 0; m_err = 0; m_wait = 0;
  endfunction

  function automatic void m_key(input int ph, input int k);
    if (k <= 9) begin
      if (ph == PH_A) begin
        if (m_a * 10 + k <= MAXV) m_a = m_a * 10 + k;
        m_disp = m_a;
      end else if (ph == PH_B) begin
        if (m_b * 10 + k <= MAXV) m_b = m_b * 10 + k;
        m_disp = m_b;
      end else if (ph == PH_SH) begin
        m_a = k; m_b = 0; m_disp = k; m_ph = PH_A;
      end
    end else if (k <= 13) begin
      if (ph == PH_A) begin
        m_op = k - 10; m_b = 0; m_ph = PH_B;
      end else if (ph == PH_B) begin
        m_op = k - 10;
      end else if (ph == PH_SH) begin
        m_a = m_disp; m_op = k - 10; m_b = 0; m_ph = PH_B;
      end
    end else if (k == 14) begin
      if (ph == PH_B) m_ph = PH_S;
    end else begin
      if (ph == PH_A) begin
        m_a = 0; m_disp = 0;
      end else m_reset();
    end
  endfunction

  initial forever begin
    int ph;
    @(posedge clck or negedge reste);
    if (!reste) m_reset();
    else begin
      ph = m_ph;
      if (key_valid && ph != PH_S && ph != PH_W) m_key(ph, int'(key_code));
      if (ph == PH_S) begin
        m_ph = PH_W; m_wait = 0;
      end else if (ph == PH_W) begin
        if (alu_done) begin
          if (alu_err) begin m_err = 1; m_ph = PH_E; end
          else begin m_disp = int'(alu_result); m_ph = PH_SH; end
        end
`ifdef ALU_TIMEOUT_EN
        else begin
          m_wait++;
          if (m_wait == TMO) begin m_err = 1; m_ph = PH_E; end
        end
`endif
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clck);
    if (chk_en) begin
      chk("state_o",   int'(state_o),   m_ph);
      chk("key_ready", int'(key_ready), int'(m_ph != PH_S && m_ph != PH_W));
      chk("alu_start", int'(alu_start), int'(m_ph == PH_S));
      chk("alu_a",     int'(alu_a),     m_a);
      chk("alu_b",     int'(alu_b),     m_b);
      chk("alu_op",    int'(alu_op),    m_op);
      chk("disp_val",  int'(disp_val),  m_disp);
      chk("disp_err",  int'(disp_err),  m_err);
    end
  end

  // ---------------- ALU stub ----------------
  int alu_lat = 3;
  bit alu_mute = 1'b0;
  bit pend = 1'b0;
  int st_cnt = 0;
  int r_val = 0;
  bit r_err = 1'b0;
  int starts = 0;

  initial forever begin
    @(negedge clck);
    alu_done = 1'b0; alu_err = 1'b0; alu_result = '0;
    if (alu_start) starts++;
    if (pend) begin
      st_cnt--;
      if (st_cnt == 0) begin
        alu_done = 1'b1; alu_result = WIDTH'(r_val); alu_err = r_err; pend = 1'b0;
      end
    end else if (alu_start && !alu_mute) begin
      pend = 1'b1; st_cnt = alu_lat; r_err = 1'b0;
      case (m_op)
        0: r_val = m_a + m_b;
        1: r_val = m_a - m_b;
        2: r_val = m_a * m_b;
        default: begin
          if (m_b == 0) begin r_val = 0; r_err = 1'b1; end
          else r_val = m_a / m_b;
        end
      endcase
      if (r_val < 0 || r_val > MAXV) r_err = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input int k);
    @(negedge clck);
    key_valid = 1'b1; key_code = 4'(k);
    @(negedge clck);
    key_valid = 1'b0;
  endtask

  task automatic wait_state(input int target, input int maxc, input string nm);
    for (int i = 0; i < maxc && int'(state_o) != target; i++) @(negedge clck);
    chk(nm, int'(state_o), target);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_state"}, int'(state_o), 0);
    chk({nm, "_a"}, int'(alu_a), 0);
    chk({nm, "_b"}, int'(alu_b), 0);
    chk({nm, "_op"}, int'(alu_op), 0);
    chk({nm, "_disp"}, int'(disp_val), 0);
    chk({nm, "_start"}, int'(alu_start), 0);
    chk({nm, "_err"}, int'(disp_err), 0);
    chk({nm, "_ready"}, int'(key_ready), 1);
  endtask

  initial begin
    int wcnt;
    #12;
    chk_reset_vals("rst");
    @(negedge clck);
    reste = 1'b1;
    chk_en = 1'b1;

    // Basic add: 12 + 7
    press(1); press(2);
    chk("a_12", int'(alu_a), 12);
    press(K_ADD); press(7); press(K_EQ);
    chk("start_pulse", int'(alu_start), 1);
    wait_state(PH_SH, 20, "add_show");
    chk("add_starts", starts, 1);
    chk("add_a", int'(alu_a), 12);
    chk("add_b", int'(alu_b), 7);
    chk("add_op", int'(alu_op), 0);
    chk("add_disp", int'(disp_val), 19);

    // Chaining: 19 - 4
    press(K_SUB); press(4); press(K_EQ);
    wait_state(PH_SH, 20, "chain_show");
    chk("chain_a", int'(alu_a), 19);
    chk("chain_b", int'(alu_b), 4);
    chk("chain_op", int'(alu_op), 1);
    chk("chain_disp", int'(disp_val), 15);
    chk("chain_starts", starts, 2);

    // Digit from SHOW starts a new calculation
    press(2);
    chk("new_state", int'(state_o), 0);
    chk("new_a", int'(alu_a), 2);
    press(K_CLR);
    chk("clr_a", int'(alu_a), 0);

    // Overflow boundary
    press(2); press(5); press(6);
    chk("ovf_256", int'(alu_a), 25);
    press(K_CLR);
    press(2); press(5); press(5);
    chk("ovf_255", int'(alu_a), 255);
    press(9);
    chk("ovf_a", int'(alu_a), 255);
    chk("ovf_disp", int'(disp_val), 255);
    chk("ovf_state", int'(state_o), 0);
    press(K_CLR);

    // Error path: 8 / 0
    press(8); press(K_DIV); press(0); press(K_EQ);
    wait_state(PH_E, 20, "err_state");
    chk("err_flag", int'(disp_err), 1);
    press(3); press(K_ADD); press(K_EQ);
    chk("err_hold_state", int'(state_o), 5);
    chk("err_hold_a", int'(alu_a), 8);
    press(K_CLR);
    chk("err_clr_err", int'(disp_err), 0);
    chk("err_clr_disp", int'(disp_val), 0);
    chk("err_clr_state", int'(state_o), 0);

    // Busy drop and asynchronous reset in WAIT
    alu_lat = 8;
    press(3); press(K_MUL); press(4); press(K_EQ);
    press(5);
    chk("busy_state", int'(state_o), 3);
    chk("busy_ready", int'(key_ready), 0);
    chk("busy_b", int'(alu_b), 4);
    #2 reste = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clck);
    reste = 1'b1;
    repeat (10) @(negedge clck);
    chk("late_done_state", int'(state_o), 0);
    chk("late_done_disp", int'(disp_val), 0);
    alu_lat = 3;

`ifdef ALU_TIMEOUT_EN
    // Timeout: ALU never answers
    alu_mute = 1'b1;
    press(1); press(K_ADD); press(1); press(K_EQ);
    wcnt = 0;
    for (int i = 0; i < 40 && int'(state_o) != PH_E; i++) begin
      @(negedge clck);
      if (int'(state_o) == PH_W) wcnt++;
    end
    chk("tmo_state", int'(state_o), 5);
    chk("tmo_cycles", wcnt, TMO);
    chk("tmo_err", int'(disp_err), 1);
    press(K_CLR);
    alu_mute = 1'b0;
`else
    wcnt = 0;
`endif

    repeat (3) @(negedge clck);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
